// File: rtl/frame_config_writer_pkg.sv
// Shared types and constants for the frame configuration writer.
// Holds the controller state encoding, command opcodes and command word field positions.
package cfg_writer_pkg;

  typedef enum logic [2:0] {
    SYNC,
    CMD,
    LOAD,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic [7:0] OP_DESYNC = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 24;
  localparam int unsigned FRAME_MSB  = 23;
  localparam int unsigned FRAME_LSB  = 16;
  localparam int unsigned COUNT_MSB  = 15;
  localparam int unsigned COUNT_LSB  = 0;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hFAB0_FAB1;

endpackage

// File: rtl/frame_config_writer_strobe_decoder.sv
// Registered binary-to-one-hot decoder with enable.
// Out-of-range indices produce an all-zero output; reset clears the output asynchronously.
module frame_strobe_decoder #(
  parameter int unsigned Width   = 20,
  parameter int unsigned IdxBits = 8
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               en,
  input  logic [IdxBits-1:0] idx,
  output logic [Width-1:0]   strobe
);

  localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      strobe <= '0;
    end else if (en && (32'(idx) < Width)) begin
      strobe <= One << idx;
    end else begin
      strobe <= '0;
    end
  end

endmodule

// File: rtl/frame_config_writer.sv
// Configuration write controller: parses sync/command words from a bitstream
// and writes frames into transparent-high latches with guaranteed setup and hold.
module frame_config_writer
  import cfg_writer_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned SetupCycles     = 1,
  parameter int unsigned StrobeCycles    = 1,
  parameter logic [FrameBitsPerRow-1:0] SyncWord = SYNC_WORD_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic [FrameBitsPerRow-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  state_t      state, nextState;
  logic [7:0]  frameIdx, nextFrameIdx;
  logic [15:0] wordCnt, nextWordCnt;
  logic [15:0] cycleCnt, nextCycleCnt;
  logic        nextError, nextDone, loadData, xfer;

  logic [7:0]  cmdOp;
  logic [7:0]  cmdFrame;
  logic [15:0] cmdCount;
  logic [16:0] rangeEnd;

  assign xfer     = s_valid && s_ready;
  assign cmdOp    = s_data[OPCODE_MSB:OPCODE_LSB];
  assign cmdFrame = s_data[FRAME_MSB:FRAME_LSB];
  assign cmdCount = s_data[COUNT_MSB:COUNT_LSB];
  // 17-bit sum so a large start index plus count cannot wrap past the check
  assign rangeEnd = {9'd0, cmdFrame} + {1'b0, cmdCount};
  assign busy     = (state != SYNC);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= SYNC;
      frameIdx  <= '0;
      wordCnt   <= '0;
      cycleCnt  <= '0;
      FrameData <= '0;
      s_ready   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state    <= nextState;
      frameIdx <= nextFrameIdx;
      wordCnt  <= nextWordCnt;
      cycleCnt <= nextCycleCnt;
      done     <= nextDone;
      error    <= nextError;
      s_ready  <= (nextState == SYNC) || (nextState == CMD) || (nextState == LOAD);
      if (loadData) begin
        FrameData <= s_data;
      end
    end
  end

  always_comb begin
    nextState    = state;
    nextFrameIdx = frameIdx;
    nextWordCnt  = wordCnt;
    nextCycleCnt = cycleCnt;
    nextError    = error;
    nextDone     = 1'b0;
    loadData     = 1'b0;
    case (state)
      SYNC: begin
        if (xfer && (s_data == SyncWord)) begin
          nextError = 1'b0;
          nextState = CMD;
        end
      end
      CMD: begin
        if (xfer) begin
          case (cmdOp)
            OP_WRITE: begin
              if (cmdCount == 16'd0) begin
                nextDone = 1'b1;
              end else if (rangeEnd > 17'(MaxFramesPerCol)) begin
                nextError = 1'b1;
                nextState = SYNC;
              end else begin
                nextFrameIdx = cmdFrame;
                nextWordCnt  = cmdCount;
                nextState    = LOAD;
              end
            end
            OP_DESYNC: nextState = SYNC;
            default: begin
              nextError = 1'b1;
              nextState = SYNC;
            end
          endcase
        end
      end
      LOAD: begin
        if (xfer) begin
          loadData     = 1'b1;
          nextCycleCnt = '0;
          nextState    = SETUP;
        end
      end
      SETUP: begin
        if (cycleCnt == 16'(SetupCycles - 1)) begin
          nextCycleCnt = '0;
          nextState    = STROBE;
        end else begin
          nextCycleCnt = cycleCnt + 16'd1;
        end
      end
      STROBE: begin
        if (cycleCnt == 16'(StrobeCycles - 1)) begin
          nextCycleCnt = '0;
          nextState    = HOLD;
        end else begin
          nextCycleCnt = cycleCnt + 16'd1;
        end
      end
      HOLD: begin
        nextFrameIdx = frameIdx + 8'd1;
        nextWordCnt  = wordCnt - 16'd1;
        if (wordCnt == 16'd1) begin
          nextDone  = 1'b1;
          nextState = CMD;
        end else begin
          nextState = LOAD;
        end
      end
      default: nextState = SYNC;
    endcase
  end

  // Strobe flop loads as the FSM enters STROBE so it is high exactly during STROBE cycles
  frame_strobe_decoder #(
    .Width   (MaxFramesPerCol),
    .IdxBits (8)
  ) u_strobeDecoder (
    .CLK    (CLK),
    .reset  (reset),
    .en     (nextState == STROBE),
    .idx    (frameIdx),
    .strobe (FrameStrobe)
  );

endmodule
